// File: rtl/exu_mdu_pkg.sv
// Shared types and helpers for the RV32M multiply/divide unit.
package exu_mdu_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    function automatic logic is_div(input mdu_op_t op);
        return op[2];
    endfunction

    function automatic logic is_signed_rs1(input mdu_op_t op);
        case (op)
            OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_rs2(input mdu_op_t op);
        case (op)
            OP_MULH, OP_DIV, OP_REM: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/exu_mdu_core.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
// Accumulator is {hi, lo}; lo starts as multiplier/dividend, hi as zero.
module exu_mdu_core #(
    parameter int unsigned XLEN = 32
) (
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN-1:0]   i_opnd,
    input  logic              i_div,
    output logic [2*XLEN-1:0] o_acc,
    output logic              o_qbit
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    always_comb begin
        w_sum   = {1'b0, i_acc[2*XLEN-1:XLEN]} + {1'b0, i_opnd};
        w_shift = {i_acc[2*XLEN-1:XLEN], i_acc[XLEN-1]};
        w_diff  = w_shift - {1'b0, i_opnd};
        o_qbit  = 1'b0;
        o_acc   = '0;
        if (i_div) begin
            // Remainder is always below the divisor, so a clear bit XLEN means no borrow.
            o_qbit = ~w_diff[XLEN];
            o_acc  = {(o_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0]),
                      i_acc[XLEN-2:0], o_qbit};
        end else if (i_acc[0]) begin
            o_acc = {w_sum, i_acc[XLEN-1:1]};
        end else begin
            o_acc = {1'b0, i_acc[2*XLEN-1:1]};
        end
    end

endmodule

// File: rtl/exu_mdu_ctrl.sv
// RV32M multiply/divide sequencer: handshake, FSM, iteration counter,
// sign fix-up, divide special-case fast path and result registers.
module exu_mdu_ctrl #(
    parameter int unsigned XLEN = exu_mdu_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MDU_i_valid,
    output logic            MDU_i_ready,
    input  logic [2:0]      MDU_i_op,
    input  logic [XLEN-1:0] MDU_i_rs1_data,
    input  logic [XLEN-1:0] MDU_i_rs2_data,
    input  logic [4:0]      MDU_i_rd,
    input  logic            MDU_i_flush,
    output logic            MDU_o_valid,
    input  logic            MDU_o_ready,
    output logic [XLEN-1:0] MDU_o_result,
    output logic [4:0]      MDU_o_rd,
    output logic            MDU_o_busy
);
    import exu_mdu_pkg::*;

    localparam int unsigned CW = $clog2(XLEN);

    mdu_state_t          r_state, w_next;
    logic [CW-1:0]       r_cnt;
    mdu_op_t             r_op;
    logic [4:0]          r_rd;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opnd;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [XLEN-1:0]     r_result;
    logic [4:0]          r_o_rd;

    mdu_op_t             w_op;
    logic                w_accept, w_last, w_fast, w_s1, w_s2;
    logic [XLEN-1:0]     w_mag1, w_mag2, w_fast_res, w_calc_res, w_quo, w_rem;
    logic [2*XLEN-1:0]   w_step, w_prod;
    logic                w_qbit;

    exu_mdu_core #(.XLEN(XLEN)) u_core (
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .i_div  (is_div(r_op)),
        .o_acc  (w_step),
        .o_qbit (w_qbit)
    );

    always_comb begin
        w_op     = mdu_op_t'(MDU_i_op);
        w_accept = MDU_i_valid & MDU_i_ready & ~MDU_i_flush;
        w_last   = (r_cnt == CW'(XLEN-1));
        w_s1     = is_signed_rs1(w_op) & MDU_i_rs1_data[XLEN-1];
        w_s2     = is_signed_rs2(w_op) & MDU_i_rs2_data[XLEN-1];
        w_mag1   = w_s1 ? -MDU_i_rs1_data : MDU_i_rs1_data;
        w_mag2   = w_s2 ? -MDU_i_rs2_data : MDU_i_rs2_data;
        // Divide-by-zero and signed overflow bypass the iteration entirely.
        w_fast   = is_div(w_op) &&
                   ((MDU_i_rs2_data == '0) ||
                    (is_signed_rs1(w_op) && MDU_i_rs1_data == {1'b1, {(XLEN-1){1'b0}}} &&
                     MDU_i_rs2_data == '1));
        if (MDU_i_rs2_data == '0)
            w_fast_res = w_op[1] ? MDU_i_rs1_data : '1;
        else
            w_fast_res = w_op[1] ? '0 : MDU_i_rs1_data;
    end

    always_comb begin
        w_prod = r_neg_q ? -w_step : w_step;
        w_quo  = r_neg_q ? -w_step[XLEN-1:0] : w_step[XLEN-1:0];
        w_rem  = r_neg_r ? -w_step[2*XLEN-1:XLEN] : w_step[2*XLEN-1:XLEN];
        case (r_op)
            OP_MUL:                       w_calc_res = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_calc_res = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_calc_res = w_quo;
            default:                      w_calc_res = w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = w_fast ? DONE : CALC;
            CALC: begin
                if (MDU_i_flush) w_next = IDLE;
                else if (w_last) w_next = DONE;
            end
            DONE: if (MDU_i_flush || MDU_o_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        MDU_i_ready  = (r_state == IDLE);
        MDU_o_busy   = (r_state != IDLE);
        MDU_o_valid  = (r_state == DONE);
        MDU_o_result = r_result;
        MDU_o_rd     = r_o_rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_op    <= OP_MUL;
            r_rd    <= '0;
            r_acc   <= '0;
            r_opnd  <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_op    <= w_op;
            r_rd    <= MDU_i_rd;
            r_acc   <= {{XLEN{1'b0}}, w_mag1};
            r_opnd  <= w_mag2;
            r_neg_q <= w_s1 ^ w_s2;
            r_neg_r <= w_s1;
        end else if (r_state == CALC) begin
            r_cnt <= r_cnt + 1'b1;
            r_acc <= w_step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_o_rd   <= '0;
        end else if (w_accept && w_fast) begin
            r_result <= w_fast_res;
            r_o_rd   <= MDU_i_rd;
        end else if (r_state == CALC && w_last && !MDU_i_flush) begin
            r_result <= w_calc_res;
            r_o_rd   <= r_rd;
        end
    end

endmodule

// File: doc/exu_mdu_ctrl.md
Name: exu_mdu_ctrl

Overview:
- Multi-cycle RV32M multiply/divide unit with its own sequencer, sitting beside the single-cycle EXU ALU.
- Accepts one M-extension op from the EXU stage through a valid/ready handshake and iterates a shared 32-step shift-add / restoring-subtract datapath.
- Returns the result and its rd tag to the MEM-bound path.
- Drives a busy/stall signal so the pipeline holds upstream stages while an op is in flight.
- Branch flush aborts the in-flight op.

Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- MDU_i_valid  in  1  op request from EXU
- MDU_i_ready  out  1  unit can accept; equals (state==IDLE)
- MDU_i_op  in  3  funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
- MDU_i_rs1_data  in  XLEN  forwarded rs1 operand
- MDU_i_rs2_data  in  XLEN  forwarded rs2 operand
- MDU_i_rd  in  5  destination tag, passed through unchanged
- MDU_i_flush  in  1  abort; driven from BRANCH_flushID
- MDU_o_valid  out  1  result available
- MDU_o_ready  in  1  downstream accepts result
- MDU_o_result  out  XLEN  result
- MDU_o_rd  out  5  tag of the result
- MDU_o_busy  out  1  stall request; equals (state!=IDLE)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset values: state=IDLE, counter=0, MDU_o_valid=0, MDU_o_result=0, MDU_o_rd=0, MDU_o_busy=0. MDU_i_ready=1 from the first cycle after reset. Inputs presented in a reset cycle are ignored. Reset mid-operation discards the op with no output.
- States:
  - IDLE → CALC on accept (i_valid & i_ready & !i_flush). Latches op, rd, operand magnitudes and sign flags; counter=0.
  - IDLE → DONE directly (fast path) on accept of a special divide case. The result is computed and registered at the accept edge.
  - CALC: one iteration per cycle. After 32 CALC cycles (counter==31 → wrap), goes to DONE. The sign-corrected result is registered on that edge.
  - DONE: o_valid=1. Goes to IDLE on o_ready.
- Latency:
  - Normal op: accept at edge E0; o_valid high in the cycle after edge E32 (33 cycles from accept).
  - Fast path: o_valid high in the cycle after E0.
- Operand signedness:
  - mulh and div/rem treat both operands as signed.
  - mulhsu treats rs1 as signed and rs2 as unsigned.
  - mulhu, divu and remu treat both operands as unsigned.
  - mul uses the low 32 bits and is sign-agnostic; it may use the unsigned path.
- Multiply: 64-bit product of magnitudes by shift-add. Negate the 64-bit product if the operand signs differ. Low half goes to mul; high half goes to mulh*.
- Divide: restoring division on magnitudes. Quotient is negated if signs differ (signed ops only). Remainder takes the sign of the dividend.
- Special cases (fast path, RISC-V spec):
  - Divisor 0: div/divu give 0xFFFFFFFF; rem/remu give the dividend.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: div gives 0x80000000; rem gives 0.
- Flush: MDU_i_flush in any state forces IDLE at the next edge and o_valid=0. The op is discarded.
  - Flush together with i_valid in IDLE: no accept.
  - Flush in DONE together with o_ready: result is dropped, but the handshake counts as not taken. Downstream qualifies with flush.
- Backpressure: while o_valid & !o_ready, MDU_o_result and MDU_o_rd hold stable, i_ready=0 and busy=1.
- No bypass: after the DONE handshake, a new op is accepted no earlier than the following cycle.

Decomposition:
- Package exu_mdu_pkg: XLEN constant, mdu_op_t enum (8 funct3 codes), mdu_state_t enum {IDLE, CALC, DONE}.
- Helper function in the package: is_div(op) and is_signed_rs1/rs2(op).
- One sub-module, exu_mdu_core: the combinational single-iteration step. Inputs are acc/partial-remainder, multiplicand/divisor, mode. Outputs are the next acc and quotient bit.
- exu_mdu_ctrl owns the FSM, counter, sign fix-up and output registers.

Test Plan:
- mul 7 × 0xFFFFFFFD, o_ready=1 → o_valid exactly 33 cycles after accept, result 0xFFFFFFEB, rd echoed; then i_ready=1.
- mulh 0x80000000×0x80000000 → 0x40000000; mulhu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; mulhsu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- div 0xFFFFFFF9 / 2 → 0xFFFFFFFD; rem same operands → 0xFFFFFFFF; divu 100/7 → 14; remu 100/7 → 2.
- Fast path: divu 5/0 → 0xFFFFFFFF and rem 5/0 → 5, each with o_valid one cycle after accept. div 0x80000000/0xFFFFFFFF → 0x80000000; rem → 0.
- Flush asserted at CALC cycle 10 → o_valid never rises, busy=0 and i_ready=1 next cycle; a following mulhu 3×5 returns 0 correctly. Flush with i_valid in IDLE → no accept.
- o_ready low 5 cycles in DONE → result/rd stable, busy=1, i_ready=0. rst asserted mid-CALC → all outputs at reset values next cycle.
